// File: rtl/fifo_readout.sv
// ---------------------------------------------------------------------------
// fifo_readout
//
// Consumer-side readout engine for a 32-bit FIFO that has a registered read
// port. It pops one word at a time, waits one cycle for the FIFO read data,
// and then sends that word MSB-first on a framed serial link.
//
// Optional feature: define FIFO_READOUT_PARITY_EN to add an even-parity bit
// after the LSB of every frame. The frame is then WIDTH+1 bits long. When the
// macro is undefined, the frame is exactly WIDTH bits and no parity logic is
// built.
//
// Parameters:
//   WIDTH       FIFO word width and number of data bits per frame (>= 2)
//   CNTW        width of the delivered-word counter
//
// Ports:
//   clock       single rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   enable      allows new pops; a word already in progress always completes
//   fifo_empty  FIFO Empty flag (registered inside the FIFO)
//   fifo_dout   FIFO DOut; valid in the cycle after fifo_read, 0 otherwise
//   fifo_read   FIFO Read; one single-cycle pulse per word
//   ser_ready   sink accepts the bit on any edge where ser_ready & ser_frame
//   ser_data    serial bit, MSB first
//   ser_frame   high while frame bits are being presented
//   busy        high whenever the engine is not idle
//   word_count  number of words fully delivered; wraps
// ---------------------------------------------------------------------------
module fifo_readout #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_read,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             busy,
  output logic [CNTW-1:0]  word_count
);

`ifdef FIFO_READOUT_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  // The shift register holds the whole frame. When parity is enabled, the
  // parity bit sits below the LSB so that it leaves the register last.
  localparam int SHW = WIDTH + PBITS;
  localparam int BCW = $clog2(SHW + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    WAIT  = 2'd2,
    SHIFT = 2'd3
  } state_t;

`ifdef FIFO_READOUT_PARITY_EN
  // Even parity over the data bits: XOR of all of them.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  state_t           state_q,      state_d;
  logic [BCW-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [SHW-1:0]   shift_q,      shift_d;
  logic             fifo_read_q,  fifo_read_d;
  logic             ser_data_q,   ser_data_d;
  logic             ser_frame_q,  ser_frame_d;
  logic             busy_q,       busy_d;
  logic [CNTW-1:0]  word_count_q, word_count_d;
  logic [SHW-1:0]   capture_s;

`ifdef FIFO_READOUT_PARITY_EN
  assign capture_s = {fifo_dout, even_parity(fifo_dout)};
`else
  assign capture_s = fifo_dout;
`endif

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fifo_read_d  = 1'b0;
    ser_data_d   = ser_data_q;
    ser_frame_d  = ser_frame_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        // fifo_empty is looked at only here. The POP/WAIT/SHIFT sequence
        // always gives its lagging update time to settle.
        if (enable && !fifo_empty) begin
          fifo_read_d = 1'b1;
          state_d     = POP;
        end else begin
          state_d     = IDLE;
        end
      end
      POP: begin
        state_d = WAIT;
      end
      WAIT: begin
        // fifo_dout is valid now because of the FIFO's one-cycle read latency.
        shift_d     = capture_s;
        ser_data_d  = capture_s[SHW-1];
        ser_frame_d = 1'b1;
        bit_cnt_d   = {BCW{1'b0}};
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (ser_ready) begin
          shift_d   = {shift_q[SHW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BCW'(1'b1);
          if (bit_cnt_q == LAST_BIT) begin
            ser_frame_d  = 1'b0;
            ser_data_d   = 1'b0;
            word_count_d = word_count_q + CNTW'(1'b1);
            state_d      = IDLE;
          end else begin
            ser_data_d   = shift_q[SHW-2];
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d     = IDLE;
        ser_frame_d = 1'b0;
        ser_data_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= {BCW{1'b0}};
      shift_q      <= {SHW{1'b0}};
      fifo_read_q  <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_frame_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= {CNTW{1'b0}};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      fifo_read_q  <= fifo_read_d;
      ser_data_q   <= ser_data_d;
      ser_frame_q  <= ser_frame_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
    end
  end

  assign fifo_read  = fifo_read_q;
  assign ser_data   = ser_data_q;
  assign ser_frame  = ser_frame_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule
